moore_pattern_tx: RTL and testbench

- Moore-style serial pattern transmitter; the transmit-side counterpart of the team's 5-bit overlapped sequence detector.
- On a start request it shifts a fixed PAT_LEN-bit pattern out on DATA_out, MSB first, one bit per clock.
- Repeats the pattern a programmable number of times, with an optional programmable idle gap of zero bits between repetitions.
- Used as stimulus/source for detector blocks and as a framing-marker generator.

---
 rtl/moore_pattern_tx.sv | 157 +++++++++++++++
 tb/tb_moore_pattern_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/moore_pattern_tx.sv
// rtl/moore_pattern_tx.sv - Moore serial pattern transmitter with repeat count and inter-repetition gap
//
// Shifts PATTERN out MSB first, one bit per clock, rep_cnt times, with gap_len
// zero bits between repetitions.
//
// Ports:
//   clk        system clock, all state on rising edge
//   res        asynchronous active-high reset
//   start      request transmission, sampled only in IDLE
//   rep_cnt    number of pattern repetitions, latched on accepted start
//   gap_len    idle zero bits between repetitions, latched on accepted start
//   abort      return to IDLE at next edge, no done pulse
//   DATA_out   serial data bit
//   valid_out  high while DATA_out carries a pattern bit
//   busy       high in SEND or GAP
//   done       one-cycle pulse on normal completion
//   sent_cnt   completed repetitions since last accepted start

module moore_pattern_tx #(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10111,
    parameter int                 CNT_W   = 8,
    parameter int                 GAP_W   = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             DATA_out,
    output logic             valid_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_cnt
);

    localparam int               IDX_W   = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [GAP_W-1:0] gap_ctr;
    logic [GAP_W-1:0] gap_lat;
    logic [CNT_W-1:0] rep_lat;

    logic [IDX_W-1:0] idx_dec;
    logic [CNT_W-1:0] sent_inc;

    assign idx_dec  = idx - 1'b1;
    assign sent_inc = sent_cnt + 1'b1;

    // Outputs are registered alongside the state so that each one is a pure
    // function of the state being entered; nothing combinational reaches a port.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= IDLE;
            idx       <= '0;
            gap_ctr   <= '0;
            gap_lat   <= '0;
            rep_lat   <= '0;
            sent_cnt  <= '0;
            DATA_out  <= 1'b0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            // sent_cnt deliberately holds so software can see how far the frame got
            state     <= IDLE;
            idx       <= '0;
            gap_ctr   <= '0;
            DATA_out  <= 1'b0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rep_lat  <= rep_cnt;
                        gap_lat  <= gap_len;
                        sent_cnt <= '0;
                        if (rep_cnt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= SEND;
                            idx       <= IDX_TOP;
                            DATA_out  <= PATTERN[IDX_TOP];
                            valid_out <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (idx == '0) begin
                        sent_cnt <= sent_inc;
                        if (sent_inc == rep_lat) begin
                            state     <= DONE;
                            DATA_out  <= 1'b0;
                            valid_out <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (gap_lat == '0) begin
                            // back-to-back repetition, no bubble
                            idx      <= IDX_TOP;
                            DATA_out <= PATTERN[IDX_TOP];
                        end else begin
                            state     <= GAP;
                            gap_ctr   <= gap_lat;
                            DATA_out  <= 1'b0;
                            valid_out <= 1'b0;
                        end
                    end else begin
                        idx      <= idx_dec;
                        DATA_out <= PATTERN[idx_dec];
                    end
                end

                GAP: begin
                    // gap_ctr is loaded with the gap length, so leaving on 1 gives
                    // exactly gap_lat zero cycles
                    if (gap_ctr == GAP_W'(1)) begin
                        state     <= SEND;
                        gap_ctr   <= '0;
                        idx       <= IDX_TOP;
                        DATA_out  <= PATTERN[IDX_TOP];
                        valid_out <= 1'b1;
                    end else begin
                        gap_ctr <= gap_ctr - 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    DATA_out  <= 1'b0;
                    valid_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moore_pattern_tx.sv
// tb/tb_moore_pattern_tx.sv - scoreboard bench for moore_pattern_tx
module tb_moore_pattern_tx;

    logic       clk;
    logic       res;
    logic       start;
    logic [7:0] rep_cnt;
    logic [3:0] gap_len;
    logic       abort;
    logic       DATA_out;
    logic       valid_out;
    logic       busy;
    logic       done;
    logic [7:0] sent_cnt;

    moore_pattern_tx dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .rep_cnt   (rep_cnt),
        .gap_len   (gap_len),
        .abort     (abort),
        .DATA_out  (DATA_out),
        .valid_out (valid_out),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       data;
        logic       valid;
        logic       busy;
        logic       done;
        logic [7:0] sent;
        int         cyc;
    } rec_t;

    rec_t       exp_q[$];
    rec_t       plan[$];
    rec_t       cur;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [4:0] pat_ref = 5'b10111;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic rec_t mk(input logic d, input logic v, input logic b,
                                input logic dn, input logic [7:0] s);
        rec_t r;
        r.data = d; r.valid = v; r.busy = b; r.done = dn; r.sent = s; r.cyc = 0;
        return r;
    endfunction

    // Whole frame laid out cycle by cycle: R patterns, G zeros between, then done.
    function automatic void expand(input logic [7:0] r, input logic [3:0] g);
        plan.delete();
        for (int rep = 0; rep < int'(r); rep++) begin
            for (int b = 4; b >= 0; b--)
                plan.push_back(mk(pat_ref[b], 1'b1, 1'b1, 1'b0, 8'(rep)));
            if (rep < int'(r) - 1)
                for (int j = 0; j < int'(g); j++)
                    plan.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'(rep + 1)));
        end
        plan.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, r));
    endfunction

    // Called at posedge+1: applies inputs for the next edge and predicts the
    // outputs for the cycle after that edge.
    task automatic drive(input logic s, input logic a, input logic [7:0] r, input logic [3:0] g);
        rec_t nxt;
        start = s; abort = a; rep_cnt = r; gap_len = g;
        if (a) begin
            plan.delete();
            nxt = mk(1'b0, 1'b0, 1'b0, 1'b0, cur.sent);
        end else if (plan.size() > 0) begin
            nxt = plan.pop_front();
        end else if (s && !cur.done) begin
            expand(r, g);
            nxt = plan.pop_front();
        end else begin
            nxt = mk(1'b0, 1'b0, 1'b0, 1'b0, cur.sent);
        end
        nxt.cyc = cyc + 1;
        exp_q.push_back(nxt);
        cur = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({DATA_out, valid_out, busy, done} !== 4'b0 || sent_cnt !== 8'd0) begin
            errors++;
            $display("FAIL %s: got data=%b valid=%b busy=%b done=%b sent=%0d, want all zero",
                     name, DATA_out, valid_out, busy, done, sent_cnt);
        end
    endtask

    // Monitor: compares every cycle for which an expectation was issued.
    always @(negedge clk) begin
        rec_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL stale: expectation for cycle %0d never compared (now %0d)", e.cyc, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if ({DATA_out, valid_out, busy, done} !== {e.data, e.valid, e.busy, e.done} ||
                sent_cnt !== e.sent) begin
                errors++;
                $display("FAIL cycle %0d: got data=%b valid=%b busy=%b done=%b sent=%0d, want data=%b valid=%b busy=%b done=%b sent=%0d",
                         cyc, DATA_out, valid_out, busy, done, sent_cnt,
                         e.data, e.valid, e.busy, e.done, e.sent);
            end
        end
    end

    initial begin
        cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        res = 1'b1; start = 1'b0; abort = 1'b0; rep_cnt = '0; gap_len = '0;
        #1;
        check_zero("reset_async_start");
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_held");
        res = 1'b0;
        idle_n(2);

        // single pattern
        drive(1'b1, 1'b0, 8'd1, 4'd0);
        idle_n(7);
        // three patterns with 2-bit gaps
        drive(1'b1, 1'b0, 8'd3, 4'd2);
        idle_n(22);
        // back-to-back
        drive(1'b1, 1'b0, 8'd2, 4'd0);
        idle_n(13);
        // maximum gap
        drive(1'b1, 1'b0, 8'd2, 4'd15);
        idle_n(30);
        // zero repetitions
        drive(1'b1, 1'b0, 8'd0, 4'd3);
        idle_n(3);

        // abort in 3rd bit of 2nd repetition, with a start pulse ignored while busy
        drive(1'b1, 1'b0, 8'd4, 4'd0);
        idle_n(2);
        drive(1'b1, 1'b0, 8'd1, 4'd0);
        idle_n(4);
        drive(1'b0, 1'b1, 8'd0, 4'd0);
        idle_n(3);
        drive(1'b1, 1'b0, 8'd2, 4'd1);
        idle_n(15);

        // abort beats start in IDLE
        drive(1'b1, 1'b1, 8'd3, 4'd0);
        idle_n(3);

        // asynchronous reset mid-SEND while DATA_out=1 and sent_cnt=1
        drive(1'b1, 1'b0, 8'd3, 4'd1);
        idle_n(6);
        #2;
        res = 1'b1;
        #1;
        check_zero("reset_mid_send");
        plan.delete();
        exp_q.delete();
        cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        res = 1'b0;
        idle_n(5);

        // randomized traffic
        repeat (1500)
            drive(($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0),
                  8'($urandom_range(0, 4)), 4'($urandom_range(0, 3)));

        // drain
        for (int i = 0; i < 2000 && plan.size() > 0; i++) idle_n(1);
        idle_n(2);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || plan.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations and %0d planned cycles, want 0 and 0",
                     exp_q.size(), plan.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
